// File: rtl/alu_decoder_pkg.sv
// alu_decoder_pkg: shared RV32I opcode/funct7 constants and ALU funct codes for the decoder
package alu_decoder_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam int ALU_FUNCT_WIDTH = 4;

   typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_NOR  = 4'd10
   } alu_funct_e;

   // alt selects the funct7=0100000 variant, which only exists for funct3 000 and 101
   function automatic alu_funct_e funct_map(input logic [2:0] f3, input logic alt);
      alu_funct_e f;
      case (f3)
         3'b000:  f = alt ? ALU_SUB : ALU_ADD;
         3'b001:  f = ALU_SLL;
         3'b010:  f = ALU_SLT;
         3'b011:  f = ALU_SLTU;
         3'b100:  f = ALU_XOR;
         3'b101:  f = alt ? ALU_SRA : ALU_SRL;
         3'b110:  f = ALU_OR;
         default: f = ALU_AND;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/alu_decoder_if.sv
// alu_decoder_if: register-read side and execute side handshake bundle of the decoder
interface alu_decoder_if #(parameter int N = 32);
   import alu_decoder_pkg::*;
   logic                       in_valid;
   logic                       in_ready;
   logic [31:0]                instr;
   logic [N-1:0]               rs1_data;
   logic [N-1:0]               rs2_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [N-1:0]               alu_x;
   logic [N-1:0]               alu_y;
   logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
   logic [4:0]                 rd;
   logic                       wb_en;
   logic                       illegal;

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_x, alu_y, alu_funct, rd, wb_en, illegal
   );

   modport master (
      output in_valid, instr, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_x, alu_y, alu_funct, rd, wb_en, illegal
   );
endinterface

// File: rtl/alu_decoder_skid_buffer.sv
// skid_buffer: two-entry valid/ready stage whose in_ready depends only on registered state
module skid_buffer #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   typedef enum logic [1:0] {EMPTY, MAIN, BOTH} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic         acc, con;

   // next state: main feeds the output, skid catches the entry accepted while output stalls
   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      in_ready  = state_q != BOTH;
      out_valid = state_q != EMPTY;
      out_data  = main_q;
      acc       = in_valid && in_ready;
      con       = out_valid && out_ready;
      case (state_q)
         EMPTY: if (acc) begin
            state_d = MAIN;
            main_d  = in_data;
         end
         MAIN: if (acc && con) begin
            main_d = in_data;
         end else if (acc) begin
            skid_d  = in_data;
            state_d = BOTH;
         end else if (con) begin
            state_d = EMPTY;
         end
         BOTH: if (con) begin
            main_d  = skid_q;
            state_d = MAIN;
         end
         default: state_d = EMPTY;
      endcase
   end

   // state and payload registers; reset clears payloads so outputs read zero
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: RV32I OP/OP-IMM/LUI to ALU operand/funct decode, one skid-buffered stage; ALU_DECODER_TRAP_EN emits illegal entries instead of dropping them
module alu_decoder
   import alu_decoder_pkg::*;
#(
   parameter int N = 32
) (
   input logic         clk,
   input logic         rst,
   alu_decoder_if.slave bus
);

   localparam int W = 2 * N + ALU_FUNCT_WIDTH + 7;

   logic [6:0]   opc, f7;
   logic [2:0]   f3;
   logic [4:0]   rd_w;
   logic [N-1:0] x, y;
   alu_funct_e   funct;
   logic         ill, shamt, wb, ill_bit, sb_valid;
   logic [W-1:0] pay_in, pay_out;

   assign opc  = bus.instr[6:0];
   assign f3   = bus.instr[14:12];
   assign f7   = bus.instr[31:25];
   assign rd_w = bus.instr[11:7];

   // decode; anything not recognised collapses to a zero-operand ADD
   always_comb begin
      x     = '0;
      y     = '0;
      funct = ALU_ADD;
      ill   = 1'b1;
      shamt = f3[1:0] == 2'b01;
      if (opc == OPC_OP) begin
         x     = bus.rs1_data;
         y     = bus.rs2_data;
         ill   = !(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
         funct = funct_map(f3, f7 == F7_ALT);
      end else if (opc == OPC_OP_IMM) begin
         x     = bus.rs1_data;
         y     = shamt ? N'(bus.instr[24:20]) : N'($signed(bus.instr[31:20]));
         ill   = shamt && !(f7 == F7_ZERO || (f7 == F7_ALT && f3[2]));
         funct = funct_map(f3, shamt && f7 == F7_ALT);
      end else if (opc == OPC_LUI) begin
         y     = N'({bus.instr[31:12], 12'b0});
         ill   = 1'b0;
      end
      if (ill) begin
         x     = '0;
         y     = '0;
         funct = ALU_ADD;
      end
   end

   assign wb = !ill && rd_w != 5'd0;

`ifdef ALU_DECODER_TRAP_EN
   assign sb_valid = bus.in_valid;
   assign ill_bit  = ill;
`else
   assign sb_valid = bus.in_valid && !ill;
   assign ill_bit  = 1'b0;
`endif

   assign pay_in = {x, y, funct, rd_w, wb, ill_bit};
   assign {bus.alu_x, bus.alu_y, bus.alu_funct, bus.rd, bus.wb_en, bus.illegal} = pay_out;

   skid_buffer #(.W(W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (sb_valid),
      .in_ready (bus.in_ready),
      .in_data  (pay_in),
      .out_valid(bus.out_valid),
      .out_ready(bus.out_ready),
      .out_data (pay_out)
   );

endmodule
